mure_slot_scheduler: RTL and testbench
======================================

Name: mure_slot_scheduler

Overview:
- Sequences the multiple-retirement serializer.
- Each cycle, the CPU pushes a group of NrRetiredInstr commit-port entries plus one common entry into the ingress FIFOs.
- This block walks the head group slot by slot, skips slots with iretire=0, and drives the output mux select toward the trace encoder under a valid/ready handshake.
- It pops the FIFOs once the group is fully emitted, and gates pushes / raises stall toward the CPU when the FIFOs near full.

Parameters:
- NrRetiredInstr, 2, commit ports per group (>=1).
- FifoDepth, 16, ingress FIFO depth (power of two); sets usage width UsageW=$clog2(FifoDepth).
- StallMargin, 2, stall_o asserts when free entries <= StallMargin.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- commit_valid_i  in  1  CPU presents a commit group this cycle.
- fifo_full_i  in  1  ingress FIFOs full (uop FIFO 0).
- fifo_usage_i  in  UsageW  ingress FIFO occupancy.
- group_valid_i  in  1  head group available (!empty).
- slot_mask_i  in  NrRetiredInstr  iretire bits of the head group.
- exc_i  in  1  head common entry carries a trap (cause valid).
- out_ready_i  in  1  trace encoder accepts a beat.
- flush_i  in  1  synchronous flush of scheduler and FIFOs.
- push_o  out  1  push to all ingress FIFOs.
- stall_o  out  1  backpressure to CPU commit.
- fifo_flush_o  out  1  flush to ingress FIFOs (= flush_i).
- pop_o  out  1  pop all ingress FIFOs.
- out_valid_o  out  1  beat valid to encoder.
- slot_sel_o  out  SelW  mux select; SelW = max(1, $clog2(NrRetiredInstr)).
- last_o  out  1  beat is the final one of its group.
- exc_only_o  out  1  beat carries only the trap; all slots empty.
- overflow_o  out  1  sticky: commit_valid_i seen while fifo_full_i.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, rem_mask=0, overflow_o=0.
  - All outputs 0; fifo_flush_o follows flush_i.
- Push side (combinational):
  - push_o = commit_valid_i & !fifo_full_i & !flush_i.
  - stall_o = fifo_full_i | (FifoDepth - fifo_usage_i <= StallMargin).
  - overflow_o is set on commit_valid_i & fifo_full_i; it is cleared only by reset.
- FSM: IDLE, EMIT, EXC.
- IDLE:
  - If group_valid_i & !flush_i, latch rem_mask = slot_mask_i and exc_q = exc_i.
  - mask != 0 -> EMIT.
  - mask == 0 & exc_i -> EXC.
  - mask == 0 & !exc_i -> pop_o=1 this cycle (empty group dropped), stay IDLE.
  - No out_valid_o in IDLE.
- EMIT:
  - out_valid_o=1; slot_sel_o = index of lowest set bit of rem_mask.
  - last_o = (rem_mask has exactly one bit set).
  - On out_valid_o & out_ready_i: clear that bit. If last_o, also pop_o=1 and go -> IDLE.
  - Without ready, hold slot_sel_o and last_o stable.
- EXC:
  - out_valid_o=1, slot_sel_o=0, last_o=1, exc_only_o=1.
  - On ready: pop_o=1, -> IDLE.
- Traps on non-empty groups: the trap travels with the group's common fields on every beat; the encoder uses last_o to place it. No extra beat is emitted.
- Latency:
  - First beat 1 cycle after group_valid_i rises in IDLE.
  - A group with k set slots takes k+1 cycles at out_ready_i=1 (one IDLE bubble after pop, because the FIFO head updates the next cycle).
- pop_o is never asserted when group_valid_i=0, and never more than once per group.
- flush_i in any state:
  - Next state IDLE, rem_mask cleared, no pop_o, out_valid_o forced 0 that cycle.
  - Flush wins over a simultaneous last-beat handshake.
- Simultaneous push and pop are independent; the FIFO handles both.
- slot_mask_i and exc_i are sampled only in IDLE; later changes are ignored.
- NrRetiredInstr=1: slot_sel_o is always 0; every beat is last.

Decomposition:
- Add to mure_pkg:
  - state enum sched_state_e {IDLE, EMIT, EXC}.
  - SelW helper function.
- Sub-module lsb_onehot_idx: lowest-set-bit index plus single-bit detect, parameterized by width. It is used for slot_sel_o and last_o.
- The counter and the FIFOs stay outside this block (common_cells fifo_v3).

Test Plan:
- N=2, group mask=2'b11, exc=0, ready=1 -> beats sel=0 (last=0), sel=1 (last=1); pop_o on cycle 2; next first beat on cycle 4.
- Mask=2'b10 -> single beat sel=1 last=1; slot 0 skipped; one pop.
- Mask=2'b00, exc=0 -> no out_valid_o; pop_o=1 in the IDLE cycle. Mask=2'b00, exc=1 -> one beat exc_only_o=1 sel=0 last=1, then pop.
- Mask=2'b11, ready low for 3 cycles on beat 0 -> sel=0 held stable, no pop; releasing ready completes the group normally.
- Depth=16, usage=14, commit_valid=1 -> stall_o=1, push_o=1. fifo_full_i=1 with commit_valid=1 -> push_o=0, overflow_o=1 and it stays 1.
- flush_i during EMIT with ready=1 on the last beat -> no pop_o, state IDLE. Async reset mid-EMIT -> all outputs 0 immediately, overflow_o cleared.

Source files
------------

// File: rtl/mure_pkg.sv
// Shared types and helpers for the multiple-retirement serializer.
//   sched_state_e : slot scheduler FSM states
//   sel_w()       : width of a slot index for a given number of commit ports
package mure_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        EXC  = 2'd2
    } sched_state_e;

    // Slot index width; never zero so a single-port build still has a select bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mure_slot_scheduler_lsb_onehot_idx.sv
// Lowest-set-bit index and exactly-one-bit detect.
//   vec_i    : input bit vector
//   idx_o    : index of the lowest set bit (0 when vec_i is zero)
//   onehot_o : vec_i has exactly one bit set
module lsb_onehot_idx
    import mure_pkg::*;
#(
    parameter  int unsigned Width = 2,
    localparam int unsigned IdxW  = sel_w(Width)
) (
    input  logic [Width-1:0] vec_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             onehot_o
);

    // Per-bit "this bit is the lowest set bit" flags.
    logic [Width-1:0] is_lsb;

    genvar gi;
    generate
        for (gi = 0; gi < Width; gi++) begin : g_lsb
            if (gi == 0) begin : g_first
                assign is_lsb[gi] = vec_i[gi];
            end else begin : g_rest
                assign is_lsb[gi] = vec_i[gi] & ~|vec_i[gi-1:0];
            end
        end
    endgenerate

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < Width; i++) begin
            if (is_lsb[i]) idx_o = IdxW'(i);
        end
    end

    // x & (x-1) clears the lowest set bit; zero afterwards means one bit only.
    assign onehot_o = (vec_i != '0) && ((vec_i & (vec_i - Width'(1))) == '0);

endmodule

// File: rtl/mure_slot_scheduler.sv
// Slot scheduler for the multiple-retirement serializer.
// Walks the head commit group slot by slot, skipping retired-empty slots, and
// drives the output mux select toward the trace encoder with valid/ready.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   commit_valid_i    : CPU presents a commit group
//   fifo_full_i       : ingress FIFOs full
//   fifo_usage_i      : ingress FIFO occupancy
//   group_valid_i     : head group available
//   slot_mask_i       : iretire bits of the head group
//   exc_i             : head common entry carries a trap
//   out_ready_i       : encoder accepts a beat
//   flush_i           : synchronous flush of scheduler and FIFOs
//   push_o / pop_o    : ingress FIFO push / pop
//   stall_o           : backpressure to CPU commit
//   fifo_flush_o      : flush to ingress FIFOs
//   out_valid_o       : beat valid
//   slot_sel_o        : mux select of the current slot
//   last_o            : final beat of its group
//   exc_only_o        : beat carries only the trap
//   overflow_o        : sticky, commit seen while FIFOs were full
module mure_slot_scheduler
    import mure_pkg::*;
#(
    parameter  int unsigned NrRetiredInstr = 2,
    parameter  int unsigned FifoDepth      = 16,
    parameter  int unsigned StallMargin    = 2,
    localparam int unsigned UsageW         = $clog2(FifoDepth),
    localparam int unsigned SelW           = sel_w(NrRetiredInstr)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      commit_valid_i,
    input  logic                      fifo_full_i,
    input  logic [UsageW-1:0]         fifo_usage_i,
    input  logic                      group_valid_i,
    input  logic [NrRetiredInstr-1:0] slot_mask_i,
    input  logic                      exc_i,
    input  logic                      out_ready_i,
    input  logic                      flush_i,
    output logic                      push_o,
    output logic                      stall_o,
    output logic                      fifo_flush_o,
    output logic                      pop_o,
    output logic                      out_valid_o,
    output logic [SelW-1:0]           slot_sel_o,
    output logic                      last_o,
    output logic                      exc_only_o,
    output logic                      overflow_o
);

    sched_state_e              state_reg, state_next;
    logic [NrRetiredInstr-1:0] rem_mask_reg, rem_mask_next;
    logic                      overflow_reg;

    logic [SelW-1:0] lsb_idx;
    logic            lsb_single;
    logic            pop_next;
    logic [31:0]     free_entries;

    lsb_onehot_idx #(
        .Width (NrRetiredInstr)
    ) u_lsb (
        .vec_i    (rem_mask_reg),
        .idx_o    (lsb_idx),
        .onehot_o (lsb_single)
    );

    // ---------------- push side ----------------
    assign free_entries = 32'(FifoDepth) - 32'(fifo_usage_i);
    assign push_o       = rst_ni & commit_valid_i & ~fifo_full_i & ~flush_i;
    assign stall_o      = rst_ni & (fifo_full_i | (free_entries <= 32'(StallMargin)));
    assign fifo_flush_o = flush_i;
    assign overflow_o   = overflow_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_reg <= 1'b0;
        end else if (commit_valid_i && fifo_full_i) begin
            overflow_reg <= 1'b1;
        end
    end

    // ---------------- scheduler FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            rem_mask_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rem_mask_reg <= rem_mask_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rem_mask_next = rem_mask_reg;
        pop_next      = 1'b0;
        out_valid_o   = 1'b0;
        slot_sel_o    = '0;
        last_o        = 1'b0;
        exc_only_o    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (group_valid_i) begin
                    rem_mask_next = slot_mask_i;
                    if (slot_mask_i != '0) begin
                        state_next = EMIT;
                    end else if (exc_i) begin
                        state_next = EXC;
                    end else begin
                        // Nothing to emit: drop the empty group right away.
                        pop_next = 1'b1;
                    end
                end
            end
            EMIT: begin
                out_valid_o = 1'b1;
                slot_sel_o  = lsb_idx;
                last_o      = lsb_single;
                if (out_ready_i) begin
                    // Retire the slot just sent (clear lowest set bit).
                    rem_mask_next = rem_mask_reg & (rem_mask_reg - NrRetiredInstr'(1));
                    if (lsb_single) begin
                        pop_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            EXC: begin
                out_valid_o = 1'b1;
                last_o      = 1'b1;
                exc_only_o  = 1'b1;
                if (out_ready_i) begin
                    pop_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Flush overrides everything, including a last-beat handshake.
        if (flush_i) begin
            state_next    = IDLE;
            rem_mask_next = '0;
            pop_next      = 1'b0;
            out_valid_o   = 1'b0;
            slot_sel_o    = '0;
            last_o        = 1'b0;
            exc_only_o    = 1'b0;
        end
    end

    // A pop without a head group would underflow the FIFOs.
    assign pop_o = rst_ni & pop_next & group_valid_i;

endmodule

// File: tb/tb_mure_slot_scheduler.sv
module tb_mure_slot_scheduler;

    localparam int unsigned N      = 2;
    localparam int unsigned Depth  = 16;
    localparam int unsigned UsageW = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             commit_valid_i;
    logic             fifo_full_i;
    logic [UsageW-1:0] fifo_usage_i;
    logic             group_valid_i;
    logic [N-1:0]     slot_mask_i;
    logic             exc_i;
    logic             out_ready_i;
    logic             flush_i;
    logic             push_o, stall_o, fifo_flush_o, pop_o;
    logic             out_valid_o, last_o, exc_only_o, overflow_o;
    logic [0:0]       slot_sel_o;

    int n_vec = 0;
    int n_err = 0;

    mure_slot_scheduler #(
        .NrRetiredInstr (N),
        .FifoDepth      (Depth),
        .StallMargin    (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .commit_valid_i (commit_valid_i),
        .fifo_full_i    (fifo_full_i),
        .fifo_usage_i   (fifo_usage_i),
        .group_valid_i  (group_valid_i),
        .slot_mask_i    (slot_mask_i),
        .exc_i          (exc_i),
        .out_ready_i    (out_ready_i),
        .flush_i        (flush_i),
        .push_o         (push_o),
        .stall_o        (stall_o),
        .fifo_flush_o   (fifo_flush_o),
        .pop_o          (pop_o),
        .out_valid_o    (out_valid_o),
        .slot_sel_o     (slot_sel_o),
        .last_o         (last_o),
        .exc_only_o     (exc_only_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_grp(input logic gv, input logic [N-1:0] m, input logic e,
                           input logic rdy, input logic fl);
        group_valid_i = gv;
        slot_mask_i   = m;
        exc_i         = e;
        out_ready_i   = rdy;
        flush_i       = fl;
        #2;
    endtask

    task automatic chk_beat(input string tag, input logic v, input logic s, input logic l,
                            input logic x, input logic p);
        chk_val({tag, ".valid"}, 32'(out_valid_o), 32'(v));
        if (v) begin
            chk_val({tag, ".sel"},  32'(slot_sel_o), 32'(s));
            chk_val({tag, ".last"}, 32'(last_o),     32'(l));
            chk_val({tag, ".exc"},  32'(exc_only_o), 32'(x));
        end
        chk_val({tag, ".pop"}, 32'(pop_o), 32'(p));
    endtask

    initial begin
        rst_ni         = 1'b0;
        commit_valid_i = 1'b1;
        fifo_full_i    = 1'b0;
        fifo_usage_i   = '0;
        group_valid_i  = 1'b1;
        slot_mask_i    = '0;
        exc_i          = 1'b0;
        out_ready_i    = 1'b1;
        flush_i        = 1'b1;
        #2;
        // Reset state: outputs held low, flush passes through.
        chk_val("rst.push",     32'(push_o),       32'd0);
        chk_val("rst.pop",      32'(pop_o),        32'd0);
        chk_val("rst.valid",    32'(out_valid_o),  32'd0);
        chk_val("rst.overflow", 32'(overflow_o),   32'd0);
        chk_val("rst.flush",    32'(fifo_flush_o), 32'd1);
        commit_valid_i = 1'b0;
        flush_i        = 1'b0;
        group_valid_i  = 1'b0;
        #10 rst_ni = 1'b1;

        // Group 11: sel0, sel1 last+pop; mask change after IDLE ignored.
        next_cyc(); set_grp(1, 2'b11, 0, 1, 0); chk_beat("g11.c0", 0, 0, 0, 0, 0);
        next_cyc(); set_grp(1, 2'b00, 0, 1, 0); chk_beat("g11.c1", 1, 0, 0, 0, 0);
        next_cyc(); set_grp(1, 2'b00, 0, 1, 0); chk_beat("g11.c2", 1, 1, 1, 0, 1);
        // Group 10: slot 0 skipped, first beat on cycle 4.
        next_cyc(); set_grp(1, 2'b10, 0, 1, 0); chk_beat("g10.c3", 0, 0, 0, 0, 0);
        next_cyc(); set_grp(1, 2'b10, 0, 1, 0); chk_beat("g10.c4", 1, 1, 1, 0, 1);
        // Empty group dropped in IDLE.
        next_cyc(); set_grp(1, 2'b00, 0, 1, 0); chk_beat("g00", 0, 0, 0, 0, 1);
        // Empty group with trap: one exc-only beat.
        next_cyc(); set_grp(1, 2'b00, 1, 1, 0); chk_beat("gexc.idle", 0, 0, 0, 0, 0);
        next_cyc(); set_grp(1, 2'b00, 0, 1, 0); chk_beat("gexc.beat", 1, 0, 1, 1, 1);
        // Group 11 with ready low for 3 cycles on beat 0.
        next_cyc(); set_grp(1, 2'b11, 0, 0, 0); chk_beat("stall.idle", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            next_cyc(); set_grp(1, 2'b11, 0, 0, 0);
            chk_beat($sformatf("stall.hold%0d", i), 1, 0, 0, 0, 0);
        end
        next_cyc(); set_grp(1, 2'b11, 0, 1, 0); chk_beat("stall.b0", 1, 0, 0, 0, 0);
        next_cyc(); set_grp(1, 2'b11, 0, 1, 0); chk_beat("stall.b1", 1, 1, 1, 0, 1);
        // No head group: no pop.
        next_cyc(); set_grp(0, 2'b00, 0, 1, 0); chk_beat("empty", 0, 0, 0, 0, 0);

        // Flush on the last beat beats the handshake.
        next_cyc(); set_grp(1, 2'b11, 0, 1, 0); chk_beat("fl.idle", 0, 0, 0, 0, 0);
        next_cyc(); set_grp(1, 2'b11, 0, 1, 0); chk_beat("fl.b0", 1, 0, 0, 0, 0);
        next_cyc(); set_grp(1, 2'b11, 0, 1, 1); chk_beat("fl.b1", 0, 0, 0, 0, 0);
        chk_val("fl.fifo_flush", 32'(fifo_flush_o), 32'd1);
        next_cyc(); set_grp(1, 2'b01, 0, 1, 0); chk_beat("fl.after", 0, 0, 0, 0, 0);
        next_cyc(); set_grp(1, 2'b01, 0, 1, 0); chk_beat("fl.next", 1, 0, 1, 0, 1);
        next_cyc(); set_grp(0, 2'b00, 0, 1, 0);

        // Push side.
        commit_valid_i = 1'b1; fifo_usage_i = 4'd14; #1;
        chk_val("push.u14.stall", 32'(stall_o), 32'd1);
        chk_val("push.u14.push",  32'(push_o),  32'd1);
        fifo_usage_i = 4'd13; #1;
        chk_val("push.u13.stall", 32'(stall_o), 32'd0);
        flush_i = 1'b1; #1;
        chk_val("push.flush",     32'(push_o),  32'd0);
        flush_i = 1'b0; fifo_usage_i = 4'd15; fifo_full_i = 1'b1; #1;
        chk_val("push.full.push",  32'(push_o),     32'd0);
        chk_val("push.full.stall", 32'(stall_o),    32'd1);
        chk_val("ovf.before",      32'(overflow_o), 32'd0);
        next_cyc();
        commit_valid_i = 1'b0; fifo_full_i = 1'b0; fifo_usage_i = '0; #1;
        chk_val("ovf.set", 32'(overflow_o), 32'd1);
        next_cyc(); next_cyc();
        chk_val("ovf.sticky", 32'(overflow_o), 32'd1);

        // Async reset mid-EMIT.
        next_cyc(); set_grp(1, 2'b11, 0, 1, 0);
        next_cyc(); set_grp(1, 2'b11, 0, 1, 0); chk_beat("ar.b0", 1, 0, 0, 0, 0);
        commit_valid_i = 1'b1;
        rst_ni = 1'b0; #1;
        chk_val("ar.valid",    32'(out_valid_o), 32'd0);
        chk_val("ar.pop",      32'(pop_o),       32'd0);
        chk_val("ar.push",     32'(push_o),      32'd0);
        chk_val("ar.last",     32'(last_o),      32'd0);
        chk_val("ar.overflow", 32'(overflow_o),  32'd0);
        commit_valid_i = 1'b0;
        #10 rst_ni = 1'b1;
        next_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
